// File: rtl/score_pkg.sv
// Shared types, default parameters and the saturating score update used by every channel.
package score_pkg;

    typedef enum logic [1:0] {CLS_LO, CLS_MID, CLS_HI} cls_t;

    localparam int DEF_CH        = 4;
    localparam int DEF_DW        = 8;
    localparam int DEF_SW        = 5;
    localparam int DEF_MAX_SCORE = 31;
    localparam int DEF_STEP_HI   = 2;
    localparam int DEF_STEP_MID  = 1;
    localparam int DEF_STEP_LO   = 1;
    localparam int DEF_ALARM_ON  = 24;
    localparam int DEF_ALARM_OFF = 8;

    // Worked in wide signed arithmetic so neither end of the range can wrap before clamping.
    function automatic int sat_update(input int score, input cls_t cls, input int max_score,
                                      input int step_hi, input int step_mid, input int step_lo);
        int n;
        case (cls)
            CLS_HI:  n = score + step_hi;
            CLS_MID: n = score + step_mid;
            default: n = score - step_lo;
        endcase
        if (n > max_score) n = max_score;
        if (n < 0)         n = 0;
        return n;
    endfunction

endpackage

// File: rtl/score_chan.sv
// One channel: a saturating score register and its hysteresis alarm flag.
module score_chan
    import score_pkg::*;
#(
    parameter int SW        = DEF_SW,
    parameter int MAX_SCORE = DEF_MAX_SCORE,
    parameter int STEP_HI   = DEF_STEP_HI,
    parameter int STEP_MID  = DEF_STEP_MID,
    parameter int STEP_LO   = DEF_STEP_LO,
    parameter int ALARM_ON  = DEF_ALARM_ON,
    parameter int ALARM_OFF = DEF_ALARM_OFF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          clr,
    input  cls_t          cls,
    output logic [SW-1:0] score,
    output logic          alarm
);

    logic [SW-1:0] score_q, score_d;
    logic          alarm_q, alarm_d;
    int            next_score;

    always_comb begin
        next_score = sat_update(int'(score_q), cls, MAX_SCORE, STEP_HI, STEP_MID, STEP_LO);
        score_d    = score_q;
        alarm_d    = alarm_q;
        if (clr) begin
            score_d = '0;
            alarm_d = 1'b0;
        end else if (en) begin
            score_d = SW'(next_score);
            // Alarm follows the new score; the band between the limits holds the old state.
            if (next_score >= ALARM_ON)
                alarm_d = 1'b1;
            else if (next_score <= ALARM_OFF)
                alarm_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            score_q <= '0;
            alarm_q <= 1'b0;
        end else begin
            score_q <= score_d;
            alarm_q <= alarm_d;
        end
    end

    assign score = score_q;
    assign alarm = alarm_q;

endmodule

// File: rtl/multi_score_cal.sv
// Multi-channel saturating score calculator: classifies tagged samples, keeps per-channel
// scores and alarms, flags dropped samples and reports the registered leading channel.
module multi_score_cal
    import score_pkg::*;
#(
    parameter int CH        = DEF_CH,
    parameter int DW        = DEF_DW,
    parameter int SW        = DEF_SW,
    parameter int MAX_SCORE = DEF_MAX_SCORE,
    parameter int STEP_HI   = DEF_STEP_HI,
    parameter int STEP_MID  = DEF_STEP_MID,
    parameter int STEP_LO   = DEF_STEP_LO,
    parameter int ALARM_ON  = DEF_ALARM_ON,
    parameter int ALARM_OFF = DEF_ALARM_OFF
) (
    input  logic                   CLK,
    input  logic                   nRST,
    input  logic                   CLRi,
    input  logic                   VALIDi,
    input  logic [$clog2(CH)-1:0]  CHi,
    input  logic [DW-1:0]          Di,
    input  logic [DW-1:0]          LOWi,
    input  logic [DW-1:0]          HIGHi,
    output logic [CH*SW-1:0]       SCOREo,
    output logic [CH-1:0]          ALARMo,
    output logic [$clog2(CH)-1:0]  LEADo,
    output logic [SW-1:0]          LEAD_SCOREo,
    output logic                   ERRo
);

    localparam int CIW = $clog2(CH);

    cls_t          cls;
    logic          sample_ok;
    logic          accept;
    logic [CH-1:0] chan_en;
    logic          err_q, err_d;
    logic [CIW-1:0] lead_q, lead_d, best_idx;
    logic [SW-1:0] lead_score_q, lead_score_d, best_score;

    always_comb begin
        cls = CLS_LO;
        if (Di >= HIGHi)
            cls = CLS_HI;
        else if (Di > LOWi)
            cls = CLS_MID;
        sample_ok = (32'(CHi) < CH) && (LOWi < HIGHi);
        accept    = VALIDi && sample_ok && !CLRi;
    end

    for (genvar k = 0; k < CH; k++) begin : g_chan
        assign chan_en[k] = accept && (32'(CHi) == k);

        score_chan #(
            .SW(SW), .MAX_SCORE(MAX_SCORE), .STEP_HI(STEP_HI), .STEP_MID(STEP_MID),
            .STEP_LO(STEP_LO), .ALARM_ON(ALARM_ON), .ALARM_OFF(ALARM_OFF)
        ) u_chan (
            .clk   (CLK),
            .rst_n (nRST),
            .en    (chan_en[k]),
            .clr   (CLRi),
            .cls   (cls),
            .score (SCOREo[k*SW +: SW]),
            .alarm (ALARMo[k])
        );
    end

    // Strict greater-than keeps the lowest index on ties.
    always_comb begin
        best_idx   = '0;
        best_score = SCOREo[SW-1:0];
        for (int k = 1; k < CH; k++) begin
            if (SCOREo[k*SW +: SW] > best_score) begin
                best_score = SCOREo[k*SW +: SW];
                best_idx   = CIW'(k);
            end
        end
        lead_d       = CLRi ? '0 : best_idx;
        lead_score_d = CLRi ? '0 : best_score;
        err_d        = VALIDi && !sample_ok && !CLRi;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            lead_q       <= '0;
            lead_score_q <= '0;
            err_q        <= 1'b0;
        end else begin
            lead_q       <= lead_d;
            lead_score_q <= lead_score_d;
            err_q        <= err_d;
        end
    end

    assign LEADo       = lead_q;
    assign LEAD_SCOREo = lead_score_q;
    assign ERRo        = err_q;

endmodule

// File: tb/tb_multi_score_cal.sv
// Self-checking bench for multi_score_cal: directed scenarios plus randomized traffic
// checked against a behavioural score/alarm/leader model.
module tb_multi_score_cal;

    localparam int CH = 4;
    localparam int SW = 5;

    logic             CLK = 1'b0;
    logic             nRST, CLRi, VALIDi;
    logic [1:0]       CHi;
    logic [7:0]       Di, LOWi, HIGHi;
    logic [CH*SW-1:0] SCOREo;
    logic [CH-1:0]    ALARMo;
    logic [1:0]       LEADo;
    logic [SW-1:0]    LEAD_SCOREo;
    logic             ERRo;

    int total = 0;
    int bad   = 0;

    int m_score[CH];
    bit m_alarm[CH];
    int m_lead, m_lead_score;
    bit m_err;

    multi_score_cal dut (
        .CLK(CLK), .nRST(nRST), .CLRi(CLRi), .VALIDi(VALIDi), .CHi(CHi),
        .Di(Di), .LOWi(LOWi), .HIGHi(HIGHi), .SCOREo(SCOREo), .ALARMo(ALARMo),
        .LEADo(LEADo), .LEAD_SCOREo(LEAD_SCOREo), .ERRo(ERRo)
    );

    always #5 CLK = ~CLK;

    task automatic model_reset();
        for (int k = 0; k < CH; k++) begin
            m_score[k] = 0;
            m_alarm[k] = 1'b0;
        end
        m_lead = 0;
        m_lead_score = 0;
        m_err = 1'b0;
    endtask

    // Model of one rising edge: leader taken from the scores as they stood before it.
    task automatic model_edge(input bit clr, input bit valid, input int ch, input int d,
                              input int lo, input int hi);
        int bi, bs, s;
        bi = 0;
        bs = m_score[0];
        for (int k = 1; k < CH; k++)
            if (m_score[k] > bs) begin
                bs = m_score[k];
                bi = k;
            end
        if (clr) begin
            model_reset();
            return;
        end
        m_lead = bi;
        m_lead_score = bs;
        m_err = valid && !(ch < CH && lo < hi);
        if (valid && ch < CH && lo < hi) begin
            s = m_score[ch];
            if (d >= hi)     s = s + 2;
            else if (d > lo) s = s + 1;
            else             s = s - 1;
            if (s > 31) s = 31;
            if (s < 0)  s = 0;
            m_score[ch] = s;
            if (s >= 24)     m_alarm[ch] = 1'b1;
            else if (s <= 8) m_alarm[ch] = 1'b0;
        end
    endtask

    task automatic cycle(input bit clr, input bit valid, input int ch, input int d,
                         input int lo, input int hi);
        @(negedge CLK);
        CLRi   = clr;
        VALIDi = valid;
        CHi    = ch[1:0];
        Di     = d[7:0];
        LOWi   = lo[7:0];
        HIGHi  = hi[7:0];
        @(posedge CLK);
        model_edge(clr, valid, ch, d, lo, hi);
        #1;
    endtask

    task automatic test_reset();
        nRST = 1'b0; CLRi = 1'b0; VALIDi = 1'b0; CHi = '0; Di = '0; LOWi = '0; HIGHi = '0;
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        total++;
        if ({SCOREo, ALARMo, LEADo, LEAD_SCOREo, ERRo} !== '0) begin
            bad++;
            $display("[TB] FAIL reset_hold got=%h want=0", {SCOREo, ALARMo, LEADo, LEAD_SCOREo, ERRo});
        end
        @(negedge CLK);
        nRST = 1'b1;
        repeat (2) cycle(0, 0, 0, 0, 0, 0);
        total++;
        if ({SCOREo, ALARMo, LEADo, LEAD_SCOREo, ERRo} !== '0) begin
            bad++;
            $display("[TB] FAIL reset_release got=%h want=0", {SCOREo, ALARMo, LEADo, LEAD_SCOREo, ERRo});
        end
    endtask

    task automatic test_saturation();
        int exp;
        cycle(1, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 16; i++) begin
            cycle(0, 1, 2, 25, 10, 20);
            exp = (2 * i > 31) ? 31 : 2 * i;
            total++;
            if (SCOREo[2*SW +: SW] !== exp[SW-1:0]) begin
                bad++;
                $display("[TB] FAIL sat_step%0d got=%0d want=%0d", i, SCOREo[2*SW +: SW], exp);
            end
        end
        total++;
        if ({SCOREo[3*SW +: SW], SCOREo[0 +: 2*SW]} !== '0) begin
            bad++;
            $display("[TB] FAIL sat_others got=%h want=0", SCOREo);
        end
        total++;
        if (ALARMo !== 4'b0100) begin
            bad++;
            $display("[TB] FAIL sat_alarm got=%b want=0100", ALARMo);
        end
    endtask

    task automatic test_underflow();
        cycle(1, 0, 0, 0, 0, 0);
        cycle(0, 1, 1, 15, 10, 20);
        total++;
        if (SCOREo[SW +: SW] !== 5'd1) begin
            bad++;
            $display("[TB] FAIL under_setup got=%0d want=1", SCOREo[SW +: SW]);
        end
        for (int i = 0; i < 3; i++) begin
            cycle(0, 1, 1, 5, 10, 20);
            total++;
            if (SCOREo[SW +: SW] !== 5'd0) begin
                bad++;
                $display("[TB] FAIL under_lo%0d got=%0d want=0", i, SCOREo[SW +: SW]);
            end
        end
        cycle(0, 1, 1, 15, 10, 20);
        total++;
        if (SCOREo[SW +: SW] !== 5'd1) begin
            bad++;
            $display("[TB] FAIL under_mid got=%0d want=1", SCOREo[SW +: SW]);
        end
    endtask

    task automatic test_hysteresis();
        cycle(1, 0, 0, 0, 0, 0);
        repeat (11) cycle(0, 1, 0, 25, 10, 20);
        total++;
        if ({SCOREo[SW-1:0], ALARMo[0]} !== {5'd22, 1'b0}) begin
            bad++;
            $display("[TB] FAIL hyst_22 got=%0d/%b want=22/0", SCOREo[SW-1:0], ALARMo[0]);
        end
        cycle(0, 1, 0, 25, 10, 20);
        total++;
        if ({SCOREo[SW-1:0], ALARMo[0]} !== {5'd24, 1'b1}) begin
            bad++;
            $display("[TB] FAIL hyst_on got=%0d/%b want=24/1", SCOREo[SW-1:0], ALARMo[0]);
        end
        repeat (15) cycle(0, 1, 0, 5, 10, 20);
        total++;
        if ({SCOREo[SW-1:0], ALARMo[0]} !== {5'd9, 1'b1}) begin
            bad++;
            $display("[TB] FAIL hyst_9 got=%0d/%b want=9/1", SCOREo[SW-1:0], ALARMo[0]);
        end
        cycle(0, 1, 0, 5, 10, 20);
        total++;
        if ({SCOREo[SW-1:0], ALARMo[0]} !== {5'd8, 1'b0}) begin
            bad++;
            $display("[TB] FAIL hyst_off got=%0d/%b want=8/0", SCOREo[SW-1:0], ALARMo[0]);
        end
        repeat (7) cycle(0, 1, 0, 25, 10, 20);
        cycle(0, 1, 0, 15, 10, 20);
        total++;
        if ({SCOREo[SW-1:0], ALARMo[0]} !== {5'd23, 1'b0}) begin
            bad++;
            $display("[TB] FAIL hyst_23 got=%0d/%b want=23/0", SCOREo[SW-1:0], ALARMo[0]);
        end
    endtask

    task automatic test_errors();
        cycle(1, 0, 0, 0, 0, 0);
        cycle(0, 1, 0, 25, 10, 20);
        cycle(0, 1, 0, 25, 20, 20);
        total++;
        if ({ERRo, SCOREo} !== {1'b1, 20'd2}) begin
            bad++;
            $display("[TB] FAIL err_equal got=%b/%h want=1/00002", ERRo, SCOREo);
        end
        cycle(0, 0, 0, 25, 20, 20);
        total++;
        if (ERRo !== 1'b0) begin
            bad++;
            $display("[TB] FAIL err_pulse got=%b want=0", ERRo);
        end
        cycle(0, 1, 0, 5, 30, 20);
        total++;
        if ({ERRo, SCOREo} !== {1'b1, 20'd2}) begin
            bad++;
            $display("[TB] FAIL err_inverted got=%b/%h want=1/00002", ERRo, SCOREo);
        end
        cycle(0, 1, 0, 15, 10, 20);
        total++;
        if ({ERRo, SCOREo} !== {1'b0, 20'd3}) begin
            bad++;
            $display("[TB] FAIL err_clear got=%b/%h want=0/00003", ERRo, SCOREo);
        end
    endtask

    task automatic test_leader();
        cycle(1, 0, 0, 0, 0, 0);
        repeat (6) cycle(0, 1, 1, 25, 10, 20);
        repeat (6) cycle(0, 1, 3, 25, 10, 20);
        cycle(0, 0, 0, 0, 0, 0);
        total++;
        if ({LEADo, LEAD_SCOREo} !== {2'd1, 5'd12}) begin
            bad++;
            $display("[TB] FAIL lead_tie got=%0d/%0d want=1/12", LEADo, LEAD_SCOREo);
        end
        cycle(0, 1, 3, 25, 10, 20);
        total++;
        if ({LEADo, LEAD_SCOREo} !== {2'd1, 5'd12}) begin
            bad++;
            $display("[TB] FAIL lead_latency got=%0d/%0d want=1/12", LEADo, LEAD_SCOREo);
        end
        cycle(0, 0, 0, 0, 0, 0);
        total++;
        if ({LEADo, LEAD_SCOREo} !== {2'd3, 5'd14}) begin
            bad++;
            $display("[TB] FAIL lead_new got=%0d/%0d want=3/14", LEADo, LEAD_SCOREo);
        end
        cycle(1, 1, 2, 25, 10, 20);
        total++;
        if ({SCOREo, ALARMo, LEADo, LEAD_SCOREo, ERRo} !== '0) begin
            bad++;
            $display("[TB] FAIL clr_valid got=%h want=0", {SCOREo, ALARMo, LEADo, LEAD_SCOREo, ERRo});
        end
        cycle(0, 0, 0, 0, 0, 0);
        total++;
        if ({SCOREo, LEADo, LEAD_SCOREo} !== '0) begin
            bad++;
            $display("[TB] FAIL clr_after got=%h want=0", {SCOREo, LEADo, LEAD_SCOREo});
        end
    endtask

    task automatic test_random();
        logic [CH*SW-1:0] exp_s;
        logic [CH-1:0]    exp_a;
        for (int n = 0; n < 400; n++) begin
            cycle($urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 3),
                  $urandom_range(0, 255), $urandom_range(0, 150), $urandom_range(0, 255));
            for (int k = 0; k < CH; k++) begin
                exp_s[k*SW +: SW] = SW'(m_score[k]);
                exp_a[k] = m_alarm[k];
            end
            total++;
            if (SCOREo !== exp_s) begin
                bad++;
                $display("[TB] FAIL rand_score n=%0d got=%h want=%h", n, SCOREo, exp_s);
            end
            total++;
            if (ALARMo !== exp_a) begin
                bad++;
                $display("[TB] FAIL rand_alarm n=%0d got=%b want=%b", n, ALARMo, exp_a);
            end
            total++;
            if ({LEADo, LEAD_SCOREo, ERRo} !== {2'(m_lead), 5'(m_lead_score), m_err}) begin
                bad++;
                $display("[TB] FAIL rand_lead_err n=%0d got=%0d/%0d/%b want=%0d/%0d/%b",
                         n, LEADo, LEAD_SCOREo, ERRo, m_lead, m_lead_score, m_err);
            end
        end
    endtask

    task automatic test_async_reset();
        repeat (5) cycle(0, 1, 0, 25, 10, 20);
        cycle(0, 1, 0, 25, 20, 20);
        @(negedge CLK);
        #2 nRST = 1'b0;
        #1;
        total++;
        if ({SCOREo, ALARMo, LEADo, LEAD_SCOREo, ERRo} !== '0) begin
            bad++;
            $display("[TB] FAIL async_reset got=%h want=0", {SCOREo, ALARMo, LEADo, LEAD_SCOREo, ERRo});
        end
        model_reset();
        @(negedge CLK);
        nRST = 1'b1;
        cycle(0, 0, 0, 0, 0, 0);
        total++;
        if ({SCOREo, ALARMo, LEADo, LEAD_SCOREo, ERRo} !== '0) begin
            bad++;
            $display("[TB] FAIL async_release got=%h want=0", {SCOREo, ALARMo, LEADo, LEAD_SCOREo, ERRo});
        end
    endtask

    initial begin
        test_reset();
        test_saturation();
        test_underflow();
        test_hysteresis();
        test_errors();
        test_leader();
        test_random();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
